// File: rtl/img_crop_stream.sv
// img_crop_stream
//   Streaming crop stage in front of the CNN input stream. It consumes a full
//   IN_ROWS x IN_COLS raster-order pixel stream and forwards only the
//   OUT_ROWS x OUT_COLS window whose top-left corner is (crop_y1, crop_x1).
//   Every other pixel is accepted and dropped. One frame is processed per
//   ap_start.
//
// Ports
//   ap_clk, ap_rst            clock (rising edge); asynchronous active-high reset
//   ap_start                  start one frame; only sampled while idle
//   ap_done, ap_ready         one-cycle pulse once the frame is consumed and the crop is emitted
//   ap_idle                   high while waiting for ap_start
//   crop_y1, crop_x1          window origin; clamped and latched on an accepted ap_start
//   in_tdata/tvalid/tready    full-frame input stream
//   out_tdata/tvalid/tready   cropped output stream (one-deep output register)
//
// Optional feature
//   Define CROP_TLAST_EN to add out_tlast. It is high with the final crop beat
//   and is held together with out_tdata while the output is stalled.
module img_crop_stream #(
    parameter int FP_TOTAL         = 16,
    parameter int IN_ROWS          = 100,
    parameter int IN_COLS          = 160,
    parameter int OUT_ROWS         = 48,
    parameter int OUT_COLS         = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_idle,
    output logic                        ap_ready,
    input  logic [IMG_ROW_BITWIDTH-1:0] crop_y1,
    input  logic [IMG_COL_BITWIDTH-1:0] crop_x1,
    input  logic [FP_TOTAL-1:0]         in_tdata,
    input  logic                        in_tvalid,
    output logic                        in_tready,
    output logic [FP_TOTAL-1:0]         out_tdata,
    output logic                        out_tvalid,
    input  logic                        out_tready
`ifdef CROP_TLAST_EN
    ,
    output logic                        out_tlast
`endif
);

    // Window arithmetic is done one bit wider, so origin + size can never wrap.
    localparam int RB = IMG_ROW_BITWIDTH + 1;
    localparam int CB = IMG_COL_BITWIDTH + 1;

    localparam logic [RB-1:0] Y1_MAX = RB'(IN_ROWS - OUT_ROWS);
    localparam logic [CB-1:0] X1_MAX = CB'(IN_COLS - OUT_COLS);

    localparam logic [IMG_ROW_BITWIDTH-1:0] ROW_LAST = IMG_ROW_BITWIDTH'(IN_ROWS - 1);
    localparam logic [IMG_COL_BITWIDTH-1:0] COL_LAST = IMG_COL_BITWIDTH'(IN_COLS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [IMG_ROW_BITWIDTH-1:0] row, y1;
    logic [IMG_COL_BITWIDTH-1:0] col, x1;

    logic [RB-1:0] y1_req, y1_clamp, row_w, y1_w;
    logic [CB-1:0] x1_req, x1_clamp, col_w, x1_w;

    logic in_window, crop_last, last_pix;
    logic accept, load, out_valid_nxt;

    // Clamp the requested origin so the window always fits inside the frame.
    assign y1_req   = {1'b0, crop_y1};
    assign x1_req   = {1'b0, crop_x1};
    assign y1_clamp = (y1_req > Y1_MAX) ? Y1_MAX : y1_req;
    assign x1_clamp = (x1_req > X1_MAX) ? X1_MAX : x1_req;

    assign row_w = {1'b0, row};
    assign col_w = {1'b0, col};
    assign y1_w  = {1'b0, y1};
    assign x1_w  = {1'b0, x1};

    assign in_window = (row_w >= y1_w) && (row_w < y1_w + RB'(OUT_ROWS)) &&
                       (col_w >= x1_w) && (col_w < x1_w + CB'(OUT_COLS));
    assign crop_last = (row_w == y1_w + RB'(OUT_ROWS - 1)) &&
                       (col_w == x1_w + CB'(OUT_COLS - 1));
    assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

    // Out-of-window beats are always taken. An in-window beat waits only
    // while the output register is full and is not being drained this cycle.
    assign in_tready     = (state == S_RUN) && (!in_window || !out_tvalid || out_tready);
    assign accept        = in_tvalid && in_tready;
    assign load          = accept && in_window;
    assign out_valid_nxt = load || (out_tvalid && !out_tready);

    always_comb begin
        state_nxt = state;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        ap_idle   = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (accept && last_pix) state_nxt = out_valid_nxt ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                if (out_tvalid && out_tready) state_nxt = S_DONE;
            end
            S_DONE: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
            y1    <= '0;
            x1    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && ap_start) begin
                y1  <= y1_clamp[RB-2:0];
                x1  <= x1_clamp[CB-2:0];
                row <= '0;
                col <= '0;
            end else if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // One-deep output register. A load in the same cycle as a drain keeps
    // valid high with the new pixel.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
`ifdef CROP_TLAST_EN
            out_tlast  <= 1'b0;
`endif
        end else if (load) begin
            out_tdata  <= in_tdata;
            out_tvalid <= 1'b1;
`ifdef CROP_TLAST_EN
            out_tlast  <= crop_last;
`endif
        end else if (out_tvalid && out_tready) begin
            out_tvalid <= 1'b0;
`ifdef CROP_TLAST_EN
            out_tlast  <= 1'b0;
`endif
        end
    end

`ifndef CROP_TLAST_EN
    // crop_last only drives out_tlast. Fold it into an unused sink otherwise.
    logic unused_crop_last;
    assign unused_crop_last = crop_last;
`endif

endmodule

// File: tb/tb_img_crop_stream.sv
// Bench for img_crop_stream. Input pixels carry their raster index
// (row*IN_COLS+col). The expected crop is built per frame from the clamped
// origin as a plain list of raster indices. One compare process checks every
// output handshake, stall stability and the done timing against that list.
module tb_img_crop_stream;

    localparam int IN_ROWS  = 100;
    localparam int IN_COLS  = 160;
    localparam int OUT_ROWS = 48;
    localparam int OUT_COLS = 48;
    localparam int NPIX     = IN_ROWS * IN_COLS;
    localparam int NOUT     = OUT_ROWS * OUT_COLS;

    logic        ap_clk, ap_rst, ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [9:0]  crop_y1, crop_x1;
    logic [15:0] in_tdata, out_tdata;
    logic        in_tvalid, in_tready, out_tvalid, out_tready;
`ifdef CROP_TLAST_EN
    logic        out_tlast;
`endif

    img_crop_stream dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .crop_y1   (crop_y1),
        .crop_x1   (crop_x1),
        .in_tdata  (in_tdata),
        .in_tvalid (in_tvalid),
        .in_tready (in_tready),
        .out_tdata (out_tdata),
        .out_tvalid(out_tvalid),
        .out_tready(out_tready)
`ifdef CROP_TLAST_EN
        ,
        .out_tlast (out_tlast)
`endif
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    int checks = 0;
    int errors = 0;
    int acc_cnt, out_cnt, done_cnt, cyc;
    int last_acc_cyc, last_hs_cyc, done_cyc, first_val, last_val;
    int exp_q[$];
    bit running = 0;
    bit rnd = 0;
    bit prev_stall = 0;
    int prev_data;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Stimulus driver. Input pixel value = number of beats accepted so far in this frame.
    initial begin
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            if (running && !ap_rst) begin
                in_tvalid  = (acc_cnt < NPIX) && (!rnd || ($urandom_range(0, 1) == 1));
                in_tdata   = 16'(acc_cnt);
                out_tready = !rnd || ($urandom_range(0, 1) == 1);
            end else begin
                in_tvalid  = 1'b0;
                out_tready = 1'b1;
            end
        end
    end

    // Compare process. Samples on the falling edge, where inputs and outputs are both settled.
    initial begin
        cyc = 0;
        forever begin
            @(negedge ap_clk);
            cyc++;
            if (ap_rst) begin
                prev_stall = 0;
            end else begin
                if (ap_done || ap_ready) chk("ready_eq_done", int'(ap_ready), int'(ap_done));
                if (prev_stall) begin
                    chk("stall_valid", int'(out_tvalid), 1);
                    chk("stall_data", int'(out_tdata), prev_data);
                end
                prev_stall = out_tvalid && !out_tready;
                prev_data  = int'(out_tdata);
                if (in_tvalid && in_tready) begin
                    acc_cnt++;
                    last_acc_cyc = cyc;
                end
                if (out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat actual=%0d expected=none", out_tdata);
                    end else begin
`ifdef CROP_TLAST_EN
                        chk("out_tlast", int'(out_tlast), (exp_q.size() == 1) ? 1 : 0);
`endif
                        chk("out_data", int'(out_tdata), exp_q.pop_front());
                    end
                    if (out_cnt == 0) first_val = int'(out_tdata);
                    last_val = int'(out_tdata);
                    out_cnt++;
                    last_hs_cyc = cyc;
                end
                if (ap_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Expected crop: raster indices of the window at the clamped origin.
    task automatic build_model(int y1, int x1);
        int cy, cx;
        cy = (y1 > IN_ROWS - OUT_ROWS) ? IN_ROWS - OUT_ROWS : y1;
        cx = (x1 > IN_COLS - OUT_COLS) ? IN_COLS - OUT_COLS : x1;
        exp_q.delete();
        for (int r = 0; r < OUT_ROWS; r++)
            for (int c = 0; c < OUT_COLS; c++)
                exp_q.push_back((cy + r) * IN_COLS + cx + c);
        acc_cnt = 0; out_cnt = 0; done_cnt = 0;
        last_acc_cyc = 0; last_hs_cyc = 0; done_cyc = 0;
        first_val = -1; last_val = -1;
    endtask

    task automatic start_frame(int y1, int x1, bit r);
        rnd = r;
        @(posedge ap_clk);
        #1;
        crop_y1  = 10'(y1);
        crop_x1  = 10'(x1);
        ap_start = 1'b1;
        running  = 1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic run_frame(string tag, int y1, int x1, bit r, int f_exp, int l_exp);
        int fin;
        build_model(y1, x1);
        chk({tag, "_model_first"}, exp_q[0], f_exp);
        chk({tag, "_model_last"}, exp_q[$], l_exp);
        start_frame(y1, x1, r);
        for (int i = 0; i < 70000 && done_cnt == 0; i++) begin
            @(negedge ap_clk);
            #1;
        end
        running = 0;
        @(negedge ap_clk);
        #1;
        chk({tag, "_idle_after"}, int'(ap_idle), 1);
        repeat (3) @(negedge ap_clk);
        #1;
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_in_accepts"}, acc_cnt, NPIX);
        chk({tag, "_out_cnt"}, out_cnt, NOUT);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_first"}, first_val, f_exp);
        chk({tag, "_last"}, last_val, l_exp);
        // Done arrives one cycle after the later of the final input accept and the final output handshake.
        fin = (last_acc_cyc > last_hs_cyc) ? last_acc_cyc : last_hs_cyc;
        chk({tag, "_done_cycle"}, done_cyc, fin + 1);
    endtask

    initial begin
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        crop_y1  = '0;
        crop_x1  = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst_idle", int'(ap_idle), 1);
        chk("rst_done", int'(ap_done), 0);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_in_tready", int'(in_tready), 0);
        chk("rst_out_tvalid", int'(out_tvalid), 0);
        chk("rst_out_tdata", int'(out_tdata), 0);
        #1;
        ap_rst = 1'b0;

        // Abort a frame with reset after 5000 accepts. No done may follow.
        build_model(0, 0);
        start_frame(0, 0, 0);
        for (int i = 0; i < 20000 && acc_cnt < 5000; i++) begin
            @(negedge ap_clk);
            #1;
        end
        chk("abort_reached", acc_cnt >= 5000 ? 1 : 0, 1);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        #1;
        chk("abort_out_tvalid", int'(out_tvalid), 0);
        chk("abort_idle", int'(ap_idle), 1);
        chk("abort_in_tready", int'(in_tready), 0);
        running = 0;
        ap_rst  = 1'b0;
        repeat (4) @(negedge ap_clk);
        #1;
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_after", int'(ap_idle), 1);

        run_frame("origin", 0, 0, 0, 0, 7567);
        run_frame("corner", 52, 112, 0, 8432, 15999);
        run_frame("clamp", 90, 200, 0, 8432, 15999);
        run_frame("random", 37, 59, 1, 5979, 13546);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
